// File: rtl/a2g_lut_dump_pkg.sv
// Shared types and status-word bit positions for the a2g LUT dump sequencer.
package a2g_lut_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int STATUS_BUSY_BIT  = 31;
  localparam int STATUS_DONE_BIT  = 30;
  localparam int STATUS_ABORT_BIT = 29;

endpackage

// File: rtl/a2g_lut_dump_fifo.sv
// Small synchronous FIFO; head word comes straight from the register array, count and sync clear exposed.
module a2g_lut_dump_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_wr     = wr_en_i && (count_q != CNT_W'(DEPTH));
  assign do_rd     = rd_en_i && (count_q != '0);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  // An empty FIFO presents zero so the stream data bus is clean after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/a2g_lut_dump_ctrl.sv
// Reads the whole a2g LUT in address order after a start edge and streams it out as eof-delimited packets.
module a2g_lut_dump_ctrl
  import a2g_lut_dump_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int PKT_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              start_in,
  input  logic              abort_in,
  output logic              lut_rd_en,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_eof,
  input  logic              tx_ready,
  output logic              done_pulse,
  output logic [31:0]       status_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LAT + 2);
  localparam int PKT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q;
  logic              start_prev_q;
  logic [ADDR_W:0]   rd_cnt_q, words_q;
  logic [ADDR_W-1:0] lut_addr_q;
  logic              rd_en_q;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic [PKT_W-1:0]  pkt_q;
  logic [2:0]        flush_q;
  logic              done_q, aborted_q;

  logic              start_edge, accept, final_acc, issue, ret, fifo_clr, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;

  assign start_edge = start_in && !start_prev_q;
  assign accept     = tx_valid && tx_ready;
  assign final_acc  = accept && (words_q == LAST_IDX);
  assign fifo_clr   = (state_q == RUN) && abort_in;
  assign ret        = vld_q[RD_LAT-1];
  // Credit check counts every read already issued, so the FIFO can never be overrun.
  assign issue      = (state_q == RUN) && !abort_in && !rd_cnt_q[ADDR_W] &&
                      ((int'(fifo_cnt) + int'(inflight_q)) < FIFO_DEPTH);

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = rd_en_q;
    case ({issue, ret})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      rd_cnt_q     <= '0;
      words_q      <= '0;
      pkt_q        <= '0;
      lut_addr_q   <= '0;
      rd_en_q      <= 1'b0;
      vld_q        <= '0;
      inflight_q   <= '0;
      flush_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      start_prev_q <= start_in;
      rd_en_q      <= issue;
      vld_q        <= vld_d;
      inflight_q   <= inflight_d;
      if (issue) begin
        lut_addr_q <= rd_cnt_q[ADDR_W-1:0];
        rd_cnt_q   <= rd_cnt_q + 1'b1;
      end
      if (accept && (state_q == RUN) && !abort_in) begin
        words_q <= words_q + 1'b1;
        pkt_q   <= (pkt_q == PKT_W'(PKT_WORDS - 1)) ? '0 : pkt_q + PKT_W'(1);
      end
      case (state_q)
        IDLE: if (start_edge) begin
          state_q    <= RUN;
          done_q     <= 1'b0;
          aborted_q  <= 1'b0;
          words_q    <= '0;
          pkt_q      <= '0;
          rd_cnt_q   <= '0;
          lut_addr_q <= '0;
        end
        RUN: if (abort_in) begin
          // Returns still in the LUT pipeline are dropped by clearing their valid bits.
          state_q    <= FLUSH;
          flush_q    <= 3'(RD_LAT - 1);
          vld_q      <= '0;
          inflight_q <= '0;
        end else if (final_acc) begin
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        FLUSH: if (flush_q == '0) begin
          state_q   <= IDLE;
          aborted_q <= 1'b1;
        end else begin
          flush_q <= flush_q - 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a2g_lut_dump_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (user_clk),
    .rst_ni    (user_rst_n),
    .clr_i     (fifo_clr),
    .wr_en_i   (ret),
    .wr_data_i (lut_rd_data),
    .rd_en_i   (accept),
    .rd_data_o (tx_data),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign tx_valid   = !fifo_empty;
  assign tx_eof     = tx_valid && ((pkt_q == PKT_W'(PKT_WORDS - 1)) || (words_q == LAST_IDX));
  assign lut_rd_en  = rd_en_q;
  assign lut_addr   = lut_addr_q;
  assign done_pulse = (state_q == DONE);

  always_comb begin
    status_out                   = '0;
    status_out[STATUS_BUSY_BIT]  = (state_q != IDLE);
    status_out[STATUS_DONE_BIT]  = done_q;
    status_out[STATUS_ABORT_BIT] = aborted_q;
    status_out[ADDR_W:0]         = words_q;
  end

endmodule
